// File: rtl/rice_block_sequencer.sv
// Per-packet block sequencer for the Rice decoder datapath.
// Drives ID fetch, reference flags, sample requests and output RAM writes.
module rice_block_sequencer #(
  parameter int J            = 16,
  parameter int REF_INTERVAL = 64,
  parameter int ADDR_W       = 10,
  parameter int NBLK_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [NBLK_W-1:0] num_blocks,
  output logic              id_req,
  input  logic              id_ack,
  output logic              dec_req,
  input  logic              dec_ack,
  output logic              ref_flag,
  output logic              datavalid,
  output logic              wren,
  output logic [ADDR_W-1:0] waddr,
  output logic              busy,
  output logic              done
);

  localparam int SW = $clog2(J + 1);
  localparam int RW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [SW-1:0] SMP_LAST = SW'(J - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REF_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_ID, REF, SAMPLE, NEXT_BLK, DONE
  } state_t;

  state_t            state, state_n;
  logic [NBLK_W-1:0] nblk;
  logic [NBLK_W-1:0] blk_cnt;
  logic [SW-1:0]     smp_cnt;
  logic [RW-1:0]     ref_cnt;
  logic              go_ok;
  logic              ack_ok;
  logic              last_blk;

  assign go_ok    = (state == IDLE) && go;
  assign ack_ok   = dec_ack && ((state == REF) || (state == SAMPLE));
  assign last_blk = (blk_cnt + NBLK_W'(1)) == nblk;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (go)
          state_n = (num_blocks == '0) ? DONE : FETCH_ID;
      FETCH_ID:
        if (id_ack)
          state_n = (ref_cnt == '0) ? REF : SAMPLE;
      REF:
        if (dec_ack)
          state_n = SAMPLE;
      SAMPLE:
        if (dec_ack && (smp_cnt == SMP_LAST))
          state_n = NEXT_BLK;
      NEXT_BLK:
        state_n = last_blk ? DONE : FETCH_ID;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Reference cadence uses a wrapping counter rather than blk_cnt mod N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nblk    <= '0;
      blk_cnt <= '0;
      smp_cnt <= '0;
      ref_cnt <= '0;
    end else if (go_ok) begin
      nblk    <= num_blocks;
      blk_cnt <= '0;
      smp_cnt <= '0;
      ref_cnt <= '0;
    end else if (state == NEXT_BLK) begin
      blk_cnt <= blk_cnt + NBLK_W'(1);
      smp_cnt <= '0;
      ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + RW'(1);
    end else if (ack_ok) begin
      smp_cnt <= smp_cnt + SW'(1);
    end
  end

  // waddr is the address counter: it names the pending write, then steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr <= '0;
    end else if (go_ok) begin
      waddr <= '0;
    end else if (wren) begin
      waddr <= waddr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_req    <= 1'b0;
      dec_req   <= 1'b0;
      ref_flag  <= 1'b0;
      datavalid <= 1'b0;
      wren      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      id_req    <= (state_n == FETCH_ID);
      dec_req   <= (state_n == REF) || (state_n == SAMPLE);
      ref_flag  <= (state_n == REF);
      datavalid <= ack_ok;
      wren      <= ack_ok;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_rice_block_sequencer.sv
// Directed bench for rice_block_sequencer: two instances, one with
// default parameters and one with a short ref cadence and narrow RAM.
module tb_rice_block_sequencer;

  logic       clk;
  logic       reset;
  logic       go;
  logic [7:0] num_blocks;
  logic       id_ack;
  logic       dec_ack;

  logic       a_id_req, a_dec_req, a_ref_flag, a_datavalid;
  logic       a_wren, a_busy, a_done;
  logic [9:0] a_waddr;
  logic       b_id_req, b_dec_req, b_ref_flag, b_datavalid;
  logic       b_wren, b_busy, b_done;
  logic [3:0] b_waddr;

  int n_cmp = 0;
  int n_bad = 0;
  logic sel = 1'b0;

  int r_w, r_abad, r_dvbad, r_ids, r_refs, r_r0, r_r1;
  int r_rise, r_done, r_dk, r_busydone, r_busyoff, r_id1, r_wa1;

  rice_block_sequencer #(
    .J(16), .REF_INTERVAL(64), .ADDR_W(10), .NBLK_W(8)
  ) dut_a (
    .clk(clk), .reset(reset), .go(go), .num_blocks(num_blocks),
    .id_req(a_id_req), .id_ack(id_ack),
    .dec_req(a_dec_req), .dec_ack(dec_ack),
    .ref_flag(a_ref_flag), .datavalid(a_datavalid),
    .wren(a_wren), .waddr(a_waddr),
    .busy(a_busy), .done(a_done)
  );

  rice_block_sequencer #(
    .J(16), .REF_INTERVAL(2), .ADDR_W(4), .NBLK_W(8)
  ) dut_b (
    .clk(clk), .reset(reset), .go(go), .num_blocks(num_blocks),
    .id_req(b_id_req), .id_ack(id_ack),
    .dec_req(b_dec_req), .dec_ack(dec_ack),
    .ref_flag(b_ref_flag), .datavalid(b_datavalid),
    .wren(b_wren), .waddr(b_waddr),
    .busy(b_busy), .done(b_done)
  );

  logic        o_idreq, o_dreq, o_ref, o_dv, o_wren, o_busy, o_done;
  logic [31:0] o_waddr;

  assign o_idreq = sel ? b_id_req    : a_id_req;
  assign o_dreq  = sel ? b_dec_req   : a_dec_req;
  assign o_ref   = sel ? b_ref_flag  : a_ref_flag;
  assign o_dv    = sel ? b_datavalid : a_datavalid;
  assign o_wren  = sel ? b_wren      : a_wren;
  assign o_busy  = sel ? b_busy      : a_busy;
  assign o_done  = sel ? b_done      : a_done;
  assign o_waddr = sel ? 32'(b_waddr) : 32'(a_waddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One packet: observe at each negedge, stop one cycle after done.
  task automatic run_pkt(input int nblk, input int per,
                         input bit stray, input bit s);
    logic        prev;
    logic [31:0] mask;
    sel = s;
    mask = s ? 32'd15 : 32'd1023;
    r_w = 0; r_abad = 0; r_dvbad = 0; r_ids = 0; r_refs = 0;
    r_r0 = -1; r_r1 = -1; r_rise = 0; r_done = 0; r_dk = 0;
    r_busydone = 0; r_busyoff = 1; r_id1 = 0; r_wa1 = -1;
    @(negedge clk);
    go = 1'b1;
    num_blocks = nblk[7:0];
    id_ack = 1'b1;
    dec_ack = (per == 1);
    prev = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      go = stray && (k == 20 || k == 21);
      if (stray) num_blocks = 8'd7;
      dec_ack = ((k % per) == 0);
      if (k == 1) begin
        r_id1 = int'(o_idreq);
        r_wa1 = int'(o_waddr);
      end
      if (o_wren) begin
        if (o_waddr !== (r_w & mask)) r_abad++;
        r_w++;
      end
      if (o_dv !== o_wren) r_dvbad++;
      if (o_ref && dec_ack) begin
        if (r_refs == 0) r_r0 = r_w;
        else if (r_refs == 1) r_r1 = r_w;
        r_refs++;
      end
      if (o_dreq && !prev) r_rise++;
      prev = o_dreq;
      if (o_idreq && id_ack) r_ids++;
      if (o_done) begin
        r_done++;
        r_dk = k;
        r_busydone = int'(o_busy);
      end
      if (r_dk != 0 && k == r_dk + 1) begin
        r_busyoff = int'(o_busy);
        break;
      end
    end
    go = 1'b0;
    dec_ack = 1'b0;
    chk("done_seen", 32'(r_dk != 0), 1);
  endtask

  initial begin
    reset = 1'b0;
    go = 1'b0;
    num_blocks = 8'd0;
    id_ack = 1'b0;
    dec_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", 32'({a_id_req, a_dec_req, a_ref_flag, a_datavalid,
                           a_wren, a_busy, a_done, a_waddr}), 0);
    chk("rst_outs_b", 32'({b_id_req, b_dec_req, b_ref_flag, b_datavalid,
                           b_wren, b_busy, b_done, b_waddr}), 0);
    reset = 1'b1;

    // Nominal: two blocks, acks every cycle.
    run_pkt(2, 1, 1'b0, 1'b0);
    chk("nom_id_req_k1", r_id1, 1);
    chk("nom_waddr_k1", r_wa1, 0);
    chk("nom_writes", r_w, 32);
    chk("nom_addr_err", r_abad, 0);
    chk("nom_dv_err", r_dvbad, 0);
    chk("nom_id_hs", r_ids, 2);
    chk("nom_refs", r_refs, 1);
    chk("nom_ref_pos", r_r0, 0);
    chk("nom_dreq_rise", r_rise, 2);
    chk("nom_dones", r_done, 1);
    chk("nom_done_cycle", r_dk, 37);
    chk("nom_busy_at_done", r_busydone, 1);
    chk("nom_busy_after", r_busyoff, 0);

    // Back-pressure with stray go / num_blocks change / id_ack.
    run_pkt(2, 3, 1'b1, 1'b0);
    chk("bp_waddr_k1", r_wa1, 0);
    chk("bp_writes", r_w, 32);
    chk("bp_addr_err", r_abad, 0);
    chk("bp_id_hs", r_ids, 2);
    chk("bp_refs", r_refs, 1);
    chk("bp_dreq_rise", r_rise, 2);
    chk("bp_dones", r_done, 1);
    chk("bp_busy_after", r_busyoff, 0);

    // Zero-block packet.
    run_pkt(0, 1, 1'b0, 1'b0);
    chk("zero_done_cycle", r_dk, 1);
    chk("zero_busy_at_done", r_busydone, 1);
    chk("zero_busy_after", r_busyoff, 0);
    chk("zero_writes", r_w, 0);
    chk("zero_id_hs", r_ids, 0);
    chk("zero_dreq_rise", r_rise, 0);

    // Ref cadence every 2 blocks, 4-bit address wrap.
    run_pkt(3, 1, 1'b0, 1'b1);
    chk("cad_writes", r_w, 48);
    chk("cad_addr_err", r_abad, 0);
    chk("cad_refs", r_refs, 2);
    chk("cad_ref0_pos", r_r0, 0);
    chk("cad_ref1_pos", r_r1, 32);
    chk("cad_id_hs", r_ids, 3);
    chk("cad_done_cycle", r_dk, 55);

    // Asynchronous reset in the middle of SAMPLE.
    sel = 1'b0;
    @(negedge clk);
    go = 1'b1;
    num_blocks = 8'd2;
    id_ack = 1'b1;
    dec_ack = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", 32'(a_busy), 1);
    chk("mid_dec_req", 32'(a_dec_req), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_outs", 32'({a_id_req, a_dec_req, a_ref_flag, a_datavalid,
                               a_wren, a_busy, a_done, a_waddr}), 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_outs", 32'({a_busy, a_done, a_wren}), 0);
    dec_ack = 1'b0;
    reset = 1'b1;
    run_pkt(2, 1, 1'b0, 1'b0);
    chk("post_rst_id_req_k1", r_id1, 1);
    chk("post_rst_waddr_k1", r_wa1, 0);
    chk("post_rst_writes", r_w, 32);
    chk("post_rst_addr_err", r_abad, 0);
    chk("post_rst_done_cycle", r_dk, 37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
